// File: rtl/count_pwm.sv
// Period-aligned PWM driven by the upstream free-running count, with a
// single-entry duty update handshake applied only on counter wrap.
module count_pwm #(
   parameter int WIDTH  = 4,
   parameter bit INVERT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] count,
   input  logic             duty_wr,
   input  logic [WIDTH-1:0] duty_in,
   output logic             duty_busy,
   output logic             duty_ovr,
   output logic             wrap_pulse,
   output logic             pwm_out
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN} st_t;

   st_t              st;
   st_t              st_next;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] duty_pend;
   logic [WIDTH-1:0] duty_act;
   logic [WIDTH-1:0] duty_eff;
   logic             wrap;
   logic             raw;
   logic             apply;
   logic             accept;
   logic             pwm_next;

   // A counter parked at zero only produces a wrap on its first zero sample.
   assign wrap = (count == '0) && (count_q != '0);

   always_comb begin
      duty_eff = (wrap && duty_busy) ? duty_pend : duty_act;
      raw      = (count < duty_eff);
      apply    = wrap && duty_busy && (st != IDLE);
      accept   = duty_wr && !duty_busy;
   end

   always_comb begin
      st_next  = st;
      pwm_next = INVERT;
      case (st)
         IDLE: begin
            if (en) st_next = ARMED;
         end
         ARMED: begin
            if (!en) begin
               st_next = IDLE;
            end else if (wrap) begin
               st_next  = RUN;
               pwm_next = raw ^ INVERT;
            end
         end
         RUN: begin
            if (!en) st_next = IDLE;
            else     pwm_next = raw ^ INVERT;
         end
         default: st_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= IDLE;
         count_q    <= '0;
         duty_pend  <= '0;
         duty_act   <= '0;
         duty_busy  <= 1'b0;
         duty_ovr   <= 1'b0;
         wrap_pulse <= 1'b0;
         pwm_out    <= INVERT;
      end else begin
         st         <= st_next;
         count_q    <= count;
         wrap_pulse <= wrap;
         pwm_out    <= pwm_next;
         // A write colliding with the applying wrap still sees busy=1, so it is dropped.
         if (duty_wr && duty_busy) duty_ovr <= 1'b1;
         if (apply) begin
            duty_act  <= duty_pend;
            duty_busy <= 1'b0;
         end else if (accept) begin
            duty_pend <= duty_in;
            duty_busy <= 1'b1;
         end
      end
   end

endmodule

// File: doc/count_pwm.md
# count_pwm

Downstream consumer of the free-running 4-bit `count` produced by the counter stage. It turns the count into a period-aligned PWM waveform, flags each counter wrap, and accepts duty-cycle updates through a single-entry handshake. Updates are applied only at a period boundary, so the output is glitch-free. The block sits between the counter and the pad/driver logic.

## Interface
- `WIDTH`, 4, width of `count` and duty values; period is 2^WIDTH cycles.
- `INVERT`, 0, output polarity; `pwm_out` = raw ^ INVERT, and the idle level is INVERT.

Clock and reset:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.

Other ports:
- `en`  in  1  run enable.
- `count`  in  WIDTH  counter value from the upstream stage, synchronous to `clk`.
- `duty_wr`  in  1  write strobe for `duty_in`.
- `duty_in`  in  WIDTH  requested duty (number of high cycles per period).
- `duty_busy`  out  1  pending duty not yet applied; writes are not accepted while high.
- `duty_ovr`  out  1  sticky flag; set when `duty_wr` arrives while `duty_busy`=1.
- `wrap_pulse`  out  1  one-cycle pulse per detected wrap.
- `pwm_out`  out  1  PWM output, registered.

## Operation
- Registers:
  - `count_q` holds the previous `count`.
  - `duty_pend` holds the captured request.
  - `duty_act` holds the duty in use.
  - State register `st`.
- Wrap detect (combinational): `wrap` = (`count` == 0) && (`count_q` != 0). If the counter is held in reset at 0, only one wrap fires.
- States:
  - IDLE: `pwm_out` = INVERT. `en`=1 moves to ARMED.
  - ARMED: `pwm_out` = INVERT, waiting for the first wrap. On `wrap`, go to RUN and drive output for that sample. `en`=0 returns to IDLE.
  - RUN: raw = (`count` < `duty_eff`). `en`=0 returns to IDLE on the next edge and forces the idle level.
- `duty_eff`:
  - = `duty_pend` when `wrap` && `duty_busy`.
  - = `duty_act` otherwise.
- Duty handshake:
  - `duty_wr` with `duty_busy`=0: capture `duty_in` into `duty_pend`, set `duty_busy`=1.
  - On a `wrap` in ARMED or RUN with `duty_busy`=1: `duty_act` ← `duty_pend`, `duty_busy` ← 0.
  - `duty_wr` while busy: the write is dropped and `duty_ovr` is set. The flag clears only on reset.
  - Simultaneous `duty_wr` and applying wrap on the same edge: apply the old pending value and clear busy. The new write is treated as arriving while busy, so it is dropped and `duty_ovr` is set.
  - In IDLE, wraps do not apply pending duty; `duty_pend` is retained.
- Arithmetic:
  - Compare is unsigned, WIDTH bits.
  - `duty` 0 gives the output permanently inactive.
  - `duty` 2^WIDTH−1 gives high for 15 of 16 cycles (WIDTH=4).
  - 100% duty is not representable.

## Timing
- Reset values: `pwm_out`=INVERT, `wrap_pulse`=0, `duty_busy`=0, `duty_ovr`=0, `duty_act`=0, `duty_pend`=0, `count_q`=0, `st`=IDLE.
- `pwm_out` latency: one cycle. It reflects the `count` sampled at edge N after edge N.
- `wrap_pulse`: asserted for exactly one cycle after the edge sampling `count`=0 with `count_q`≠0.
- `duty_busy`: rises the edge after an accepted `duty_wr`. It falls the edge that samples the wrap.
- New duty takes effect for the whole period starting at `count`=0. There is no mid-period change.
- ARMED→RUN happens on the wrap edge, so the first active output cycle corresponds to `count`=0.
- Reset mid-period: all outputs return to reset values immediately. After release, the block is in IDLE.

## Test plan
- Reset and defaults: hold `reset`=0 for 2 cycles with `count` running. Require `pwm_out`=0, `wrap_pulse`=0, `duty_busy`=0 and `duty_ovr`=0 throughout, for INVERT=0.
- Basic PWM: write duty 4 while in IDLE, then `en`=1. After the first wrap, `pwm_out` is high for 4 cycles and low for 12, repeating every 16 cycles. `wrap_pulse` fires once per 16 cycles.
- Update at boundary: write duty 10 at `count`=6 of a period running duty 4. Require:
  - `duty_busy`=1 until the wrap.
  - The current period stays at 4 high cycles.
  - The next period has 10 high cycles.
- Overrun: issue two `duty_wr` writes (3, then 9) within one period. Require that 3 is applied, 9 is dropped, and `duty_ovr`=1 stays set.
- Extremes: duty 0 gives `pwm_out` constantly 0. Duty 15 gives high for `count` 0–14 and low at 15.
- Disable and upstream reset: drop `en` mid-period and require `pwm_out`=0 on the next edge. Re-enable and require a wait for the next wrap. Hold the upstream counter at 0 for 5 cycles and require exactly one `wrap_pulse`.
